// File: rtl/sprite_layer_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_layer_arbiter
//
// Two-stage pipelined fixed-priority arbiter. For every accepted pixel
// request it picks the highest-priority enabled sprite layer that covers the
// pixel (lowest index wins) and emits that layer's SDRAM word address. When
// no enabled layer covers the pixel it emits DEFAULT_ADDR and flags bg.
// It also keeps a sticky per-frame record of which enabled layers were hit.
//
// Ports
//   clk_50       in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   in_valid     in   pixel request present
//   in_ready     out  request accepted this cycle (combinational from out_ready)
//   layer_hit    in   [NUM_LAYERS]        bit i: layer i covers the pixel
//   layer_addr   in   [NUM_LAYERS*ADDR_W] layer i address at [i*ADDR_W +: ADDR_W]
//   layer_en     in   [NUM_LAYERS]        enable mask, sampled with the request
//   frame_start  in   one-cycle pulse, clears frame_hits
//   out_valid    out  output beat valid
//   out_ready    in   downstream takes the beat
//   Address      out  [ADDR_W] selected address
//   layer_idx    out  [IDX_W]  winning layer (0 for background)
//   bg           out  no enabled layer hit
//   multi_hit    out  two or more enabled layers hit
//   frame_hits   out  [NUM_LAYERS] sticky OR of enabled hits this frame
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. A producer holding valid
// high must keep its payload stable until the transfer; out_valid and the
// S2 payload are never changed while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module sprite_layer_arbiter #(
    parameter int                NUM_LAYERS   = 8,
    parameter int                ADDR_W       = 25,
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = '0,
    parameter int                IDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clk_50,
    input  logic                         Reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic                         frame_start,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            Address,
    output logic [IDX_W-1:0]             layer_idx,
    output logic                         bg,
    output logic                         multi_hit,
    output logic [NUM_LAYERS-1:0]        frame_hits
);

    // -------------------------------------------------------------------------
    // Stage 1: masked hit vector and the full address bundle
    // -------------------------------------------------------------------------
    logic                         s1_valid;
    logic [NUM_LAYERS-1:0]        s1_m;
    logic [NUM_LAYERS*ADDR_W-1:0] s1_addr;

    logic                  s1_adv;
    logic                  accept;
    logic [NUM_LAYERS-1:0] in_m;

    // S1 may move forward whenever S2 is empty or is being drained this cycle.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    // No skid buffer: S1 can only take a new request if it is empty or
    // emptying into S2 on this same edge.
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;
    // The mask is applied at accept time so in-flight beats keep their mask.
    assign in_m     = layer_hit & layer_en;

    always_ff @(posedge clk_50 or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_m     <= '0;
            s1_addr  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_m     <= in_m;
            s1_addr  <= layer_addr;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Priority encode of the S1 contents
    // -------------------------------------------------------------------------
    logic              enc_found;
    logic              enc_multi;
    logic [IDX_W-1:0]  enc_idx;
    logic [ADDR_W-1:0] enc_addr;

    // Scan from index 0 upward; the first set bit wins, any later set bit
    // means at least two layers hit.
    always_comb begin
        enc_found = 1'b0;
        enc_multi = 1'b0;
        enc_idx   = '0;
        enc_addr  = DEFAULT_ADDR;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (s1_m[i]) begin
                if (enc_found) begin
                    enc_multi = 1'b1;
                end else begin
                    enc_found = 1'b1;
                    enc_idx   = IDX_W'(i);
                    enc_addr  = s1_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: registered output beat
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_50 or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            Address   <= DEFAULT_ADDR;
            layer_idx <= '0;
            bg        <= 1'b1;
            multi_hit <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            Address   <= enc_addr;
            layer_idx <= enc_idx;
            bg        <= !enc_found;
            multi_hit <= enc_multi;
        end else if (out_ready) begin
            // Beat consumed and nothing behind it; payload is left as-is.
            out_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Per-frame layer hit accumulation
    // -------------------------------------------------------------------------
    // A frame_start that coincides with an accept clears first, then records
    // the accepted hits, so the new frame starts with that request's layers.
    always_ff @(posedge clk_50 or posedge Reset) begin
        if (Reset) begin
            frame_hits <= '0;
        end else if (frame_start) begin
            frame_hits <= accept ? in_m : '0;
        end else if (accept) begin
            frame_hits <= frame_hits | in_m;
        end
    end

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_layer_arbiter
//
// Self-checking bench for sprite_layer_arbiter (8 layers, 25-bit addresses).
// A behavioural model keeps accepted beats in an ordered queue; each beat's
// expected output is computed directly from the priority rule when the
// request is accepted. A beat is visible at the output once two clock edges
// have passed since the edge before which it was presented, and the pipeline
// refuses input only when it holds two beats and the reader is stalled.
// -----------------------------------------------------------------------------
module tb_sprite_layer_arbiter;

    localparam int NL = 8;
    localparam int AW = 25;
    localparam int IW = 3;
    localparam logic [AW-1:0] DEF = '0;

    // ---------------- clock / reset ----------------
    logic clk_50 = 1'b0;
    logic Reset;
    always #5 clk_50 = ~clk_50;

    // ---------------- DUT signals ----------------
    logic             in_valid;
    logic             in_ready;
    logic [NL-1:0]    layer_hit;
    logic [NL*AW-1:0] layer_addr;
    logic [NL-1:0]    layer_en;
    logic             frame_start;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    Address;
    logic [IW-1:0]    layer_idx;
    logic             bg;
    logic             multi_hit;
    logic [NL-1:0]    frame_hits;

    logic [AW-1:0] addr_arr [NL];

    always_comb begin
        layer_addr = '0;
        for (int i = 0; i < NL; i++) layer_addr[i*AW +: AW] = addr_arr[i];
    end

    sprite_layer_arbiter #(
        .NUM_LAYERS  (NL),
        .ADDR_W      (AW),
        .DEFAULT_ADDR(DEF)
    ) dut (
        .clk_50     (clk_50),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .layer_hit  (layer_hit),
        .layer_addr (layer_addr),
        .layer_en   (layer_en),
        .frame_start(frame_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Address    (Address),
        .layer_idx  (layer_idx),
        .bg         (bg),
        .multi_hit  (multi_hit),
        .frame_hits (frame_hits)
    );

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] idx;
        logic          bg;
        logic          multi;
        int            acc;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] pop_log[$];
    logic [NL-1:0] exp_fh;
    int            cyc;
    int            total;
    int            bad;
    logic          last_acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected beat straight from the rule: lowest enabled hit index wins.
    function automatic beat_t ref_beat(input logic [NL-1:0] m, input int acc);
        beat_t b;
        b.bg    = 1'b1;
        b.addr  = DEF;
        b.idx   = '0;
        b.multi = ($countones(m) >= 2);
        b.acc   = acc;
        for (int i = NL - 1; i >= 0; i--) begin
            if (m[i]) begin
                b.bg   = 1'b0;
                b.addr = addr_arr[i];
                b.idx  = IW'(i);
            end
        end
        return b;
    endfunction

    function automatic bit mdl_out_valid();
        return (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 2);
    endfunction

    function automatic bit mdl_in_ready();
        return !((exp_q.size() == 2) && !out_ready);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already driven; checks outputs,
    // advances one clock, updates the model, returns at the next falling edge.
    task automatic tick();
        bit            acc;
        bit            hs;
        logic [NL-1:0] m;
        beat_t         nb;
        #1;
        check_eq("in_ready", in_ready, mdl_in_ready());
        check_eq("out_valid", out_valid, mdl_out_valid());
        check_eq("frame_hits", frame_hits, exp_fh);
        if (mdl_out_valid()) begin
            check_eq("address", Address, exp_q[0].addr);
            check_eq("layer_idx", layer_idx, exp_q[0].idx);
            check_eq("bg", bg, exp_q[0].bg);
            check_eq("multi_hit", multi_hit, exp_q[0].multi);
        end
        acc = in_valid && mdl_in_ready();
        hs  = mdl_out_valid() && out_ready;
        m   = layer_hit & layer_en;
        nb  = ref_beat(m, cyc);
        @(posedge clk_50);
        if (hs) begin
            pop_log.push_back(exp_q[0].addr);
            void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back(nb);
        if (frame_start) exp_fh = acc ? m : '0;
        else if (acc)    exp_fh = exp_fh | m;
        last_acc = acc;
        cyc++;
        @(negedge clk_50);
    endtask

    task automatic set_idle();
        in_valid    = 1'b0;
        layer_hit   = '0;
        layer_en    = '1;
        frame_start = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        exp_q.delete();
        exp_fh = '0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_bg", bg, 1'b1);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_address", Address, DEF);
        check_eq("rst_layer_idx", layer_idx, 0);
        check_eq("rst_multi_hit", multi_hit, 1'b0);
        check_eq("rst_frame_hits", frame_hits, 0);
        @(negedge clk_50);
        Reset = 1'b0;
    endtask

    task automatic request(input logic [NL-1:0] hit, input logic [NL-1:0] en);
        in_valid  = 1'b1;
        layer_hit = hit;
        layer_en  = en;
        tick();
        in_valid  = 1'b0;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, expected test done");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    logic [AW-1:0] bp_a [4];
    int            accepted;

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        last_acc = 1'b0;
        exp_fh   = '0;
        for (int i = 0; i < NL; i++) addr_arr[i] = AW'($urandom);
        set_idle();
        do_reset();

        // Two hits, layer 2 outranks layer 5.
        addr_arr[2] = 25'h0001234;
        addr_arr[5] = 25'h0005678;
        request(8'b0010_0100, 8'hFF);
        check_eq("t1_valid", out_valid, 1'b1);
        check_eq("t1_addr", Address, 25'h0001234);
        check_eq("t1_idx", layer_idx, 2);
        check_eq("t1_bg", bg, 1'b0);
        check_eq("t1_multi", multi_hit, 1'b1);

        // No hit: background.
        request(8'h00, 8'hFF);
        check_eq("t2_addr", Address, DEF);
        check_eq("t2_bg", bg, 1'b1);
        check_eq("t2_idx", layer_idx, 0);
        check_eq("t2_multi", multi_hit, 1'b0);

        // Layer 0 masked off, layer 1 wins alone.
        request(8'b0000_0011, 8'b1111_1110);
        check_eq("t3_idx", layer_idx, 1);
        check_eq("t3_addr", Address, addr_arr[1]);
        check_eq("t3_multi", multi_hit, 1'b0);

        // All layers disabled: background.
        request(8'hFF, 8'h00);
        check_eq("t3b_bg", bg, 1'b1);
        tick();

        // Backpressure: 4 requests, reader stalled 5 cycles.
        bp_a[0] = 25'h0A0A0A0; bp_a[1] = 25'h0B1B1B1;
        bp_a[2] = 25'h0C2C2C2; bp_a[3] = 25'h0D3D3D3;
        pop_log.delete();
        accepted  = 0;
        out_ready = 1'b0;
        layer_en  = 8'hFF;
        layer_hit = 8'h01;
        for (int c = 0; c < 5; c++) begin
            in_valid    = 1'b1;
            addr_arr[0] = bp_a[accepted];
            tick();
            if (last_acc) accepted++;
        end
        check_eq("bp_accepts", accepted, 2);
        #1;
        check_eq("bp_in_ready_low", in_ready, 1'b0);
        @(negedge clk_50);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (accepted < 4 || exp_q.size() > 0); c++) begin
            in_valid = (accepted < 4);
            if (accepted < 4) addr_arr[0] = bp_a[accepted];
            tick();
            if (last_acc) accepted++;
        end
        in_valid = 1'b0;
        check_eq("bp_beats", pop_log.size(), 4);
        for (int j = 0; j < 4; j++)
            check_eq("bp_order", (j < pop_log.size()) ? pop_log[j] : '0, bp_a[j]);

        // frame_hits accumulation and clear-then-set.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        request(8'h01, 8'hFF);
        request(8'h10, 8'hFF);
        check_eq("fh_accum", frame_hits, 8'h11);
        frame_start = 1'b1;
        in_valid    = 1'b1;
        layer_hit   = 8'h04;
        tick();
        frame_start = 1'b0;
        in_valid    = 1'b0;
        check_eq("fh_restart", frame_hits, 8'h04);
        tick();

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        layer_hit = 8'h02;
        for (int c = 0; c < 3; c++) tick();
        in_valid = 1'b0;
        check_eq("pre_rst_full", exp_q.size(), 2);
        do_reset();
        out_ready   = 1'b1;
        addr_arr[7] = 25'h1ABCDEF;
        in_valid    = 1'b1;
        layer_hit   = 8'h80;
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_early", out_valid, 1'b0);
        tick();
        check_eq("post_rst_valid", out_valid, 1'b1);
        check_eq("post_rst_addr", Address, 25'h1ABCDEF);
        check_eq("post_rst_idx", layer_idx, 7);

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       layer_hit = '0;
                1:       layer_hit = NL'(1) << $urandom_range(0, NL - 1);
                default: layer_hit = NL'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) layer_en = NL'($urandom);
            for (int i = 0; i < NL; i++) addr_arr[i] = AW'($urandom);
            tick();
        end

        // Drain.
        set_idle();
        for (int c = 0; c < 4; c++) tick();
        check_eq("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
